// File: rtl/register_file_sb.sv
// Multi-port register file with load scoreboard: ALU writeback (port A), load return (port B),
// two bypassed combinational read ports, per-register pending bits, stall and hazard flags.
module register_file_sb #(
    parameter int unsigned DataWidth  = 16,
    parameter int unsigned SelectSize = 3,
    parameter int unsigned ZeroReg    = 0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       REG_WE,
    input  logic [DataWidth-1:0]       DIn,
    input  logic [SelectSize-1:0]      REG_Dst,
    input  logic                       LD_Valid,
    input  logic [SelectSize-1:0]      LD_Dst,
    input  logic [DataWidth-1:0]       LD_DIn,
    input  logic                       Lock,
    input  logic [SelectSize-1:0]      REG_LockDst,
    input  logic [SelectSize-1:0]      REG_Src1,
    input  logic [SelectSize-1:0]      REG_Src2,
    output logic [DataWidth-1:0]       SRC1,
    output logic [DataWidth-1:0]       SRC2,
    output logic                       Stall1,
    output logic                       Stall2,
    output logic [2**SelectSize-1:0]   Pending,
    output logic                       Conflict
);

    localparam int unsigned Depth = 2 ** SelectSize;

    logic [DataWidth-1:0]  regs_q [Depth];
    logic [DataWidth-1:0]  regs_d [Depth];
    logic [Depth-1:0]      pending_q;
    logic [Depth-1:0]      pending_d;
    logic                  conflict_q;
    logic                  conflict_d;

    logic                  a_zero;
    logic                  b_zero;
    logic                  lk_zero;
    logic                  a_en;
    logic                  b_en;
    logic                  lk_en;

    logic [SelectSize-1:0] rd_sel   [2];
    logic [DataWidth-1:0]  rd_data  [2];
    logic                  rd_stall [2];

    // Accesses to a hardwired-zero register 0 are squashed before they reach any state.
    always_comb begin
        a_zero  = (ZeroReg != 0) && (REG_Dst == '0);
        b_zero  = (ZeroReg != 0) && (LD_Dst == '0);
        lk_zero = (ZeroReg != 0) && (REG_LockDst == '0);
        a_en    = !REG_WE && !a_zero;
        b_en    = LD_Valid && !b_zero;
        lk_en   = Lock && !lk_zero;
    end

    assign rd_sel[0] = REG_Src1;
    assign rd_sel[1] = REG_Src2;

    // Read mux: load return beats ALU writeback beats stored value.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p]  = regs_q[rd_sel[p]];
            rd_stall[p] = pending_q[rd_sel[p]];
            if ((ZeroReg != 0) && (rd_sel[p] == '0)) begin
                rd_data[p] = '0;
            end else if (LD_Valid && (LD_Dst == rd_sel[p])) begin
                rd_data[p] = LD_DIn;
            end else if (!REG_WE && (REG_Dst == rd_sel[p])) begin
                rd_data[p] = DIn;
            end
            if (LD_Valid && (LD_Dst == rd_sel[p])) begin
                rd_stall[p] = 1'b0;
            end
        end
    end

    assign SRC1   = rd_data[0];
    assign SRC2   = rd_data[1];
    assign Stall1 = rd_stall[0];
    assign Stall2 = rd_stall[1];

    // Next-state: port B is applied after port A so it wins a same-register collision,
    // and a new lock is applied after the load clear so it wins on the same register.
    always_comb begin
        regs_d     = regs_q;
        pending_d  = pending_q;
        conflict_d = 1'b0;

        if (a_en) begin
            regs_d[REG_Dst] = DIn;
        end
        if (b_en) begin
            regs_d[LD_Dst]    = LD_DIn;
            pending_d[LD_Dst] = 1'b0;
        end
        if (lk_en) begin
            pending_d[REG_LockDst] = 1'b1;
        end

        if (a_en && b_en && (REG_Dst == LD_Dst)) begin
            conflict_d = 1'b1;
        end
        if (b_en && !pending_q[LD_Dst]) begin
            conflict_d = 1'b1;
        end
        if (a_en && pending_q[REG_Dst]) begin
            conflict_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            regs_q     <= '{default: '0};
            pending_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            conflict_q <= conflict_d;
        end
    end

    assign Pending  = pending_q;
    assign Conflict = conflict_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Randomized + directed bench for register_file_sb; checks a ZeroReg=0 and a ZeroReg=1 instance
// against an array-based reference model driven by identical stimulus.
module tb_register_file_sb;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 3;
    localparam int unsigned ND = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_we;
    logic [DW-1:0] din;
    logic [SW-1:0] reg_dst;
    logic          ld_valid;
    logic [SW-1:0] ld_dst;
    logic [DW-1:0] ld_din;
    logic          lock;
    logic [SW-1:0] lock_dst;
    logic [SW-1:0] src1;
    logic [SW-1:0] src2;

    logic [DW-1:0] src1_o   [2];
    logic [DW-1:0] src2_o   [2];
    logic          stall1_o [2];
    logic          stall2_o [2];
    logic [ND-1:0] pend_o   [2];
    logic          conf_o   [2];

    logic [DW-1:0] m_mem  [2][ND];
    logic [ND-1:0] m_pend [2];
    logic          m_conf [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_file_sb #(.DataWidth(DW), .SelectSize(SW), .ZeroReg(0)) u_dut (
        .Clk(clk), .Reset(reset), .REG_WE(reg_we), .DIn(din), .REG_Dst(reg_dst),
        .LD_Valid(ld_valid), .LD_Dst(ld_dst), .LD_DIn(ld_din), .Lock(lock),
        .REG_LockDst(lock_dst), .REG_Src1(src1), .REG_Src2(src2),
        .SRC1(src1_o[0]), .SRC2(src2_o[0]), .Stall1(stall1_o[0]), .Stall2(stall2_o[0]),
        .Pending(pend_o[0]), .Conflict(conf_o[0])
    );

    register_file_sb #(.DataWidth(DW), .SelectSize(SW), .ZeroReg(1)) u_dut_z (
        .Clk(clk), .Reset(reset), .REG_WE(reg_we), .DIn(din), .REG_Dst(reg_dst),
        .LD_Valid(ld_valid), .LD_Dst(ld_dst), .LD_DIn(ld_din), .Lock(lock),
        .REG_LockDst(lock_dst), .REG_Src1(src1), .REG_Src2(src2),
        .SRC1(src1_o[1]), .SRC2(src2_o[1]), .Stall1(stall1_o[1]), .Stall2(stall2_o[1]),
        .Pending(pend_o[1]), .Conflict(conf_o[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instance z has register 0 hardwired to zero.
    function automatic logic is_zero(input int z, input logic [SW-1:0] sel);
        return (z == 1) && (sel == 3'd0);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int z, input logic [SW-1:0] sel);
        if (is_zero(z, sel))                 return '0;
        if (ld_valid && ld_dst == sel)       return ld_din;
        if (!reg_we && reg_dst == sel)       return din;
        return m_mem[z][sel];
    endfunction

    function automatic logic exp_stall(input int z, input logic [SW-1:0] sel);
        return m_pend[z][sel] && !(ld_valid && ld_dst == sel);
    endfunction

    // Compare every output of both instances against the model, mid-cycle.
    task automatic settle();
        @(negedge clk);
        for (int z = 0; z < 2; z++) begin
            check_eq($sformatf("src1[%0d] sel%0d", z, src1), 32'(src1_o[z]), 32'(exp_rd(z, src1)));
            check_eq($sformatf("src2[%0d] sel%0d", z, src2), 32'(src2_o[z]), 32'(exp_rd(z, src2)));
            check_eq($sformatf("stall1[%0d]", z), 32'(stall1_o[z]), 32'(exp_stall(z, src1)));
            check_eq($sformatf("stall2[%0d]", z), 32'(stall2_o[z]), 32'(exp_stall(z, src2)));
            check_eq($sformatf("pending[%0d]", z), 32'(pend_o[z]), 32'(m_pend[z]));
            check_eq($sformatf("conflict[%0d]", z), 32'(conf_o[z]), 32'(m_conf[z]));
        end
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUTs.
    task automatic step();
        for (int z = 0; z < 2; z++) begin
            if (reset) begin
                for (int i = 0; i < ND; i++) m_mem[z][i] = '0;
                m_pend[z] = '0;
                m_conf[z] = 1'b0;
            end else begin
                logic wa, wb, lk;
                wa = !reg_we && !is_zero(z, reg_dst);
                wb = ld_valid && !is_zero(z, ld_dst);
                lk = lock && !is_zero(z, lock_dst);
                m_conf[z] = (wa && wb && reg_dst == ld_dst) || (wb && !m_pend[z][ld_dst]) ||
                            (wa && m_pend[z][reg_dst]);
                if (wa) m_mem[z][reg_dst] = din;
                if (wb) m_mem[z][ld_dst] = ld_din;
                if (wb) m_pend[z][ld_dst] = 1'b0;
                if (lk) m_pend[z][lock_dst] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        step();
    endtask

    task automatic idle();
        reset    = 1'b0;
        reg_we   = 1'b1;
        ld_valid = 1'b0;
        lock     = 1'b0;
        din      = 16'hDEAD;
        ld_din   = 16'hCAFE;
        reg_dst  = 3'd0;
        ld_dst   = 3'd0;
        lock_dst = 3'd0;
    endtask

    initial begin
        idle();
        src1  = 3'd0;
        src2  = 3'd0;
        reset = 1'b1;
        // First edge: DUT state still unknown, so no comparisons yet.
        step();
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        for (int s = 0; s < ND; s++) begin
            src1 = 3'(s);
            src2 = 3'(ND - 1 - s);
            settle();
            check_eq("rst_src1", 32'(src1_o[0]), 32'h0);
            check_eq("rst_src2", 32'(src2_o[0]), 32'h0);
            step();
        end

        reg_we = 1'b0; din = 16'h00A0; reg_dst = 3'd0; src1 = 3'd0;
        settle();
        check_eq("bypass_r0", 32'(src1_o[0]), 32'h00A0);
        check_eq("bypass_r0_z", 32'(src1_o[1]), 32'h0);
        step();
        idle();
        settle();
        check_eq("held_r0", 32'(src1_o[0]), 32'h00A0);
        step();

        reg_we = 1'b0; reg_dst = 3'd3; din = 16'h1234; cyc();
        reg_dst = 3'd5; din = 16'hBEEF; cyc();
        idle(); src1 = 3'd3; src2 = 3'd5;
        settle();
        check_eq("r3", 32'(src1_o[0]), 32'h1234);
        check_eq("r5", 32'(src2_o[0]), 32'hBEEF);
        step();

        lock = 1'b1; lock_dst = 3'd4; src1 = 3'd4; cyc();
        idle();
        settle();
        check_eq("lock_stall", 32'(stall1_o[0]), 32'h1);
        check_eq("lock_pend", 32'(pend_o[0]), 32'h10);
        step();
        ld_valid = 1'b1; ld_dst = 3'd4; ld_din = 16'h5A5A;
        settle();
        check_eq("ld_unstall", 32'(stall1_o[0]), 32'h0);
        check_eq("ld_bypass", 32'(src1_o[0]), 32'h5A5A);
        step();
        idle();
        settle();
        check_eq("ld_pend_clr", 32'(pend_o[0]), 32'h0);
        check_eq("ld_r4", 32'(src1_o[0]), 32'h5A5A);
        check_eq("ld_noconf", 32'(conf_o[0]), 32'h0);
        step();

        reg_we = 1'b0; reg_dst = 3'd2; din = 16'h1111;
        ld_valid = 1'b1; ld_dst = 3'd2; ld_din = 16'h2222; src1 = 3'd2;
        settle();
        check_eq("coll_bypass", 32'(src1_o[0]), 32'h2222);
        step();
        idle();
        settle();
        check_eq("coll_r2", 32'(src1_o[0]), 32'h2222);
        check_eq("coll_conf1", 32'(conf_o[0]), 32'h1);
        step();
        settle();
        check_eq("coll_conf0", 32'(conf_o[0]), 32'h0);
        step();

        ld_valid = 1'b1; ld_dst = 3'd6; ld_din = 16'h6666; cyc();
        idle(); src1 = 3'd6;
        settle();
        check_eq("ld_np_r6", 32'(src1_o[0]), 32'h6666);
        check_eq("ld_np_conf", 32'(conf_o[0]), 32'h1);
        step();

        lock = 1'b1; lock_dst = 3'd1; cyc();
        idle(); reg_we = 1'b0; reg_dst = 3'd1; din = 16'h0101; cyc();
        idle(); src1 = 3'd1;
        settle();
        check_eq("waw_r1", 32'(src1_o[0]), 32'h0101);
        check_eq("waw_conf", 32'(conf_o[0]), 32'h1);
        check_eq("waw_pend1", 32'(pend_o[0][1]), 32'h1);
        step();
        ld_valid = 1'b1; ld_dst = 3'd1; ld_din = 16'h0F0F; cyc();

        idle(); reg_we = 1'b0; reg_dst = 3'd0; din = 16'hFFFF;
        lock = 1'b1; lock_dst = 3'd0; src1 = 3'd0;
        settle();
        check_eq("z_wr_bypass", 32'(src1_o[1]), 32'h0);
        step();
        idle();
        settle();
        check_eq("z_r0", 32'(src1_o[1]), 32'h0);
        check_eq("z_pend0", 32'(pend_o[1][0]), 32'h0);
        check_eq("z_conf", 32'(conf_o[1]), 32'h0);
        step();

        reg_we = 1'b0; reg_dst = 3'd7; din = 16'h7777; lock = 1'b1; lock_dst = 3'd7; cyc();
        idle(); src1 = 3'd7;
        settle();
        check_eq("r7_pend", 32'(pend_o[0][7]), 32'h1);
        check_eq("r7_val", 32'(src1_o[0]), 32'h7777);
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check_eq("rst_mid_pend", 32'(pend_o[0]), 32'h0);
        check_eq("rst_mid_r7", 32'(src1_o[0]), 32'h0);
        step();

        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(63) == 0);
            reg_we   = 1'($urandom_range(1));
            ld_valid = ($urandom_range(2) == 0);
            lock     = ($urandom_range(3) == 0);
            din      = 16'($urandom);
            ld_din   = 16'($urandom);
            reg_dst  = 3'($urandom);
            ld_dst   = 3'($urandom);
            lock_dst = 3'($urandom);
            src1     = 3'($urandom);
            src2     = 3'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor to the single-write-port RegisterFile. Provides 2^SelectSize registers of DataWidth bits, with two combinational read ports and two write ports. Port A is the ALU writeback; port B is the load-return. A per-register pending scoreboard tracks outstanding loads and drives stall and conflict flags. It sits between decode, writeback and the load unit of the A09 datapath.

Parameters:
DataWidth, 16, width of each register and of all data ports
SelectSize, 3, register select width; Depth = 2**SelectSize registers
ZeroReg, 0, if 1 then register 0 is hardwired to zero, and writes and locks to it are ignored

Ports:
Clk  input  1  system clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
REG_WE  input  1  port A write enable, active-low (0 = write)
DIn  input  DataWidth  port A write data
REG_Dst  input  SelectSize  port A destination register
LD_Valid  input  1  port B (load-return) write strobe, active-high
LD_Dst  input  SelectSize  port B destination register
LD_DIn  input  DataWidth  port B write data
Lock  input  1  active-high; marks REG_LockDst pending (load issued)
REG_LockDst  input  SelectSize  register to mark pending
REG_Src1  input  SelectSize  read port 1 select
REG_Src2  input  SelectSize  read port 2 select
SRC1  output  DataWidth  read port 1 data (combinational, bypassed)
SRC2  output  DataWidth  read port 2 data (combinational, bypassed)
Stall1  output  1  source 1 is pending and not being returned this cycle
Stall2  output  1  same for source 2
Pending  output  Depth  scoreboard bit vector, bit i = register i pending
Conflict  output  1  registered one-cycle hazard pulse

Behaviour:
- Reset (synchronous, Reset=1 at rising edge): all registers = 0, Pending = 0, Conflict = 0. Reset overrides every write and lock in the same cycle. Reset mid-load discards the outstanding pending state.
- Writes happen at the rising edge: port A when REG_WE=0, port B when LD_Valid=1.
- Both ports targeting the same register in the same cycle: LD_DIn is stored and DIn is discarded.
- Different registers: both writes are performed in the same edge.
- Read mux for each port, in priority order:
  1. LD_Valid and LD_Dst matches the select: output LD_DIn.
  2. Otherwise REG_WE=0 and REG_Dst matches the select: output DIn.
  3. Otherwise output the stored value.
  Write-through latency is therefore 0 cycles; the stored value is visible from the cycle after the edge.
- ZeroReg=1: select 0 always reads 0, bypass is excluded for register 0, writes to register 0 are dropped, Lock to register 0 is ignored, and Pending[0] is always 0.
- Scoreboard at the edge:
  - Lock=1 sets Pending[REG_LockDst].
  - LD_Valid=1 clears Pending[LD_Dst].
  - Lock and LD_Valid to the same register in the same cycle: the data is written and Pending stays 1 (the new lock wins).
- Stall1 = Pending[REG_Src1] AND NOT (LD_Valid AND LD_Dst==REG_Src1). Stall2 is analogous. Both are combinational.
- Conflict is registered: it asserts for exactly one cycle after an edge where any of these held:
  (a) both ports wrote the same register;
  (b) LD_Valid targeted a register whose Pending bit was 0;
  (c) port A wrote a register whose Pending bit was 1 (WAW hazard). The write is still performed.
  Conflict returns to 0 on the next edge unless a new hazard occurs. Writes dropped due to ZeroReg do not raise Conflict.
- Registers hold their value indefinitely when no write or reset occurs.
- There are no X outputs after the first reset edge.

Test Plan:
- Reset=1 for 2 edges, then read all 8 registers -> SRC1=SRC2=0x0000, Pending=0x00, Conflict=0.
- REG_WE=0, DIn=0x00A0, REG_Dst=0, REG_Src1=0 -> SRC1=0x00A0 in the same cycle via bypass. After the edge with REG_WE=1, SRC1 still reads 0x00A0. Write R3=0x1234 and R5=0xBEEF, then Src1=3, Src2=5 -> SRC1=0x1234, SRC2=0xBEEF.
- Lock=1, REG_LockDst=4, then Src1=4:
  - Stall1=1 and Pending=0x10 after the edge.
  - Next cycle LD_Valid=1, LD_Dst=4, LD_DIn=0x5A5A -> Stall1=0 and SRC1=0x5A5A in that cycle, then Pending=0x00 and R4=0x5A5A.
- Same-register collision: REG_WE=0, REG_Dst=2, DIn=0x1111, with LD_Valid=1, LD_Dst=2, LD_DIn=0x2222 -> SRC1(sel 2)=0x2222 in that cycle, R2=0x2222 after the edge, Conflict=1 for one cycle, then 0.
- LD_Valid to non-pending R6 -> R6 updated and Conflict pulses once. Port A write to pending R1 (locked earlier) -> R1 written, Conflict pulses, Pending[1] remains 1.
- With ZeroReg=1, write 0xFFFF to R0 and Lock R0 -> SRC1(sel 0)=0x0000, Pending[0]=0, Conflict=0. Assert Reset during an outstanding lock on R7 -> Pending=0x00 and R7=0 after the edge.
